aftab_dawu_controller: RTL and testbench
========================================

# aftab_DAWU_controller

Sequencing FSM for the AFTAB Data Adjust Write Unit (DAWU). It accepts one store request from the core control unit, loads address, data and size into the DAWU datapath, and then drives one byte-wide memory write per accepted memory handshake until the byte counter matches the stored size. It also raises a misaligned-store exception when that check is compiled in, and reports completion back to the core. It sits between the core controller, the DAWU datapath and the byte-wide data memory port.

## Interface
Parameters:
- none. The datapath width (32) and the byte-counter width (2) are fixed.

Ports:
- clk  input  1  system clock; every register updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- startDAWU  input  1  store request; sampled only in IDLE.
- memReady  input  1  memory has accepted the byte currently driven.
- coCnt  input  1  datapath compare: byte counter == stored nBytes.
- storeMisalignedFlag  input  1  combinational output of the datapath error detector.
- LdAddr, LdData, LdNumBytes  output  1 each  datapath register loads.
- iniCnt  output  1  initialise the byte counter to initValueCnt.
- incCnt  output  1  increment the byte counter.
- initValueCnt  output  2  counter initial value; constant 2'b00.
- zeroAddr, zeroData, zeroNumBytes, zeroCnt  output  1 each  clear the datapath registers.
- enableAddr, enableData  output  1 each  drive the address and data buses (tri-state enables).
- checkMisalignedDAWU  output  1  enables the datapath error detector.
- writeMem  output  1  byte write strobe to memory.
- completeDAWU  output  1  one-cycle pulse: store finished.
- dawuMisalignedException  output  1  one-cycle pulse: store aborted as misaligned.

## Operation
- States: IDLE, WRITE, DONE, ERROR. Encoding is free; there are no unreachable lock-up states, and any illegal state goes to IDLE.
- IDLE: all outputs are 0 except checkMisalignedDAWU, which is asserted combinationally when startDAWU=1 (macro enabled).
  - If startDAWU=1 and (macro enabled and storeMisalignedFlag=1): go to ERROR. No register loads occur.
  - If startDAWU=1 otherwise: assert LdAddr, LdData, LdNumBytes and iniCnt in the same cycle, then go to WRITE.
- WRITE: enableAddr=enableData=writeMem=1. The bus carries address+counter and the selected data byte.
  - If memReady=0: hold; the bus stays stable and the counter does not change.
  - If memReady=1 and coCnt=0: assert incCnt and stay in WRITE.
  - If memReady=1 and coCnt=1: last byte. Do not increment; go to DONE.
- DONE: completeDAWU=1 and zeroAddr=zeroData=zeroNumBytes=zeroCnt=1 for one cycle, then IDLE.
- ERROR: dawuMisalignedException=1 for one cycle, then IDLE. No memory write is ever issued for an aborted store.
- Size encoding is nBytes = bytes−1 (0 = byte, 1 = halfword, 3 = word). The number of writes issued is nBytes+1.
- startDAWU outside IDLE is ignored. The requester holds it until completeDAWU or the exception pulse; re-assertion in that pulse cycle is not sampled.
- All outputs are Moore-decoded from state, except the IDLE load/check signals, which are Mealy on startDAWU.

## Timing
- Reset: state = IDLE and every output is 0 in the cycle after rst is sampled high. rst wins over startDAWU and memReady in the same cycle.
- Reset mid-WRITE aborts immediately: writeMem drops next cycle and no completeDAWU is emitted. Datapath registers are cleared by their own rst.
- Start in cycle T (aligned): WRITE from T+1. With memReady held at 1, byte k is written in cycle T+1+k. completeDAWU is high in cycle T+nBytes+2, and IDLE is reached at T+nBytes+3.
- Each memReady=0 cycle in WRITE adds exactly one cycle of latency.
- Misaligned start in cycle T: dawuMisalignedException is high in T+1 and IDLE is reached at T+2.
- Back-to-back: a new start is accepted in the first IDLE cycle, which is 1 cycle after the DONE or ERROR pulse.

## Configuration
- AFTAB_DAWU_MISALIGN_CHECK_EN defined:
  - checkMisalignedDAWU is asserted on start.
  - storeMisalignedFlag routes to ERROR.
- Undefined:
  - checkMisalignedDAWU is tied 0.
  - storeMisalignedFlag is ignored.
  - The ERROR state and dawuMisalignedException logic are removed, and the port is tied 0.
  - Misaligned stores proceed byte-serially as normal stores.

## Test plan
- Word store, addr 0x100, nBytes=3, memReady=1 -> writeMem is high for 4 cycles, incCnt pulses 3 times, completeDAWU arrives exactly 5 cycles after start.
- Byte store, nBytes=0, with memReady low for 2 cycles then high -> writeMem is held stable for 3 cycles with no incCnt, then DONE; total latency 4 cycles.
- Misaligned halfword, addr[1:0]=2'b11, nBytes=1, macro on -> dawuMisalignedException pulses at T+1, with no LdAddr and no writeMem. With the macro off -> 2 writes and completeDAWU.
- rst asserted in the 2nd WRITE cycle of a word store -> IDLE next cycle, all outputs 0, no completeDAWU. A following start is accepted normally.
- startDAWU held high through a full word store -> exactly one transaction. A second start is accepted only in the first IDLE cycle after the completeDAWU pulse.

Source files
------------

// File: rtl/aftab_dawu_controller.sv
// Sequencing FSM for the AFTAB Data Adjust Write Unit: load, byte-serial write, done/error.
// Optional misaligned-store abort is compiled in with AFTAB_DAWU_MISALIGN_CHECK_EN.
module aftab_dawu_controller (
   input  logic       clk,
   input  logic       rst,
   input  logic       startDAWU,
   input  logic       memReady,
   input  logic       coCnt,
   input  logic       storeMisalignedFlag,
   output logic       LdAddr,
   output logic       LdData,
   output logic       LdNumBytes,
   output logic       iniCnt,
   output logic       incCnt,
   output logic [1:0] initValueCnt,
   output logic       zeroAddr,
   output logic       zeroData,
   output logic       zeroNumBytes,
   output logic       zeroCnt,
   output logic       enableAddr,
   output logic       enableData,
   output logic       checkMisalignedDAWU,
   output logic       writeMem,
   output logic       completeDAWU,
   output logic       dawuMisalignedException
);

   localparam int unsigned CNT_W   = 2;
   localparam int unsigned STATE_W = 2;

   localparam logic [STATE_W-1:0] S_IDLE  = 2'b00;
   localparam logic [STATE_W-1:0] S_WRITE = 2'b01;
   localparam logic [STATE_W-1:0] S_DONE  = 2'b10;
   localparam logic [STATE_W-1:0] S_ERROR = 2'b11;

   logic [STATE_W-1:0] r_state;
   logic [STATE_W-1:0] w_next_state;

   // Byte counter always restarts from byte 0 of the stored word.
   assign initValueCnt = CNT_W'(0);

`ifndef AFTAB_DAWU_MISALIGN_CHECK_EN
   logic w_unused_misaligned;
   assign w_unused_misaligned = storeMisalignedFlag;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and output decode; IDLE loads/check are Mealy on startDAWU
   always_comb begin
      w_next_state            = r_state;
      LdAddr                  = 1'b0;
      LdData                  = 1'b0;
      LdNumBytes              = 1'b0;
      iniCnt                  = 1'b0;
      incCnt                  = 1'b0;
      zeroAddr                = 1'b0;
      zeroData                = 1'b0;
      zeroNumBytes            = 1'b0;
      zeroCnt                 = 1'b0;
      enableAddr              = 1'b0;
      enableData              = 1'b0;
      checkMisalignedDAWU     = 1'b0;
      writeMem                = 1'b0;
      completeDAWU            = 1'b0;
      dawuMisalignedException = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (startDAWU) begin
`ifdef AFTAB_DAWU_MISALIGN_CHECK_EN
               checkMisalignedDAWU = 1'b1;
               if (storeMisalignedFlag) begin
                  w_next_state = S_ERROR;
               end else begin
                  LdAddr       = 1'b1;
                  LdData       = 1'b1;
                  LdNumBytes   = 1'b1;
                  iniCnt       = 1'b1;
                  w_next_state = S_WRITE;
               end
`else
               LdAddr       = 1'b1;
               LdData       = 1'b1;
               LdNumBytes   = 1'b1;
               iniCnt       = 1'b1;
               w_next_state = S_WRITE;
`endif
            end
         end

         S_WRITE: begin
            enableAddr = 1'b1;
            enableData = 1'b1;
            writeMem   = 1'b1;
            // Bus held stable until memory accepts; last byte leaves the counter alone.
            if (memReady) begin
               if (coCnt) begin
                  w_next_state = S_DONE;
               end else begin
                  incCnt = 1'b1;
               end
            end
         end

         S_DONE: begin
            completeDAWU = 1'b1;
            zeroAddr     = 1'b1;
            zeroData     = 1'b1;
            zeroNumBytes = 1'b1;
            zeroCnt      = 1'b1;
            w_next_state = S_IDLE;
         end

`ifdef AFTAB_DAWU_MISALIGN_CHECK_EN
         S_ERROR: begin
            dawuMisalignedException = 1'b1;
            w_next_state            = S_IDLE;
         end
`endif

         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_aftab_dawu_controller.sv
// Self-checking bench for aftab_dawu_controller with a small datapath model and
// a transaction-level reference for write counts, counter effects and latency.
module tb_aftab_dawu_controller;

`ifdef AFTAB_DAWU_MISALIGN_CHECK_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       startDAWU;
   logic       memReady;
   logic       coCnt;
   logic       storeMisalignedFlag;
   logic       LdAddr, LdData, LdNumBytes, iniCnt, incCnt;
   logic [1:0] initValueCnt;
   logic       zeroAddr, zeroData, zeroNumBytes, zeroCnt;
   logic       enableAddr, enableData, checkMisalignedDAWU, writeMem;
   logic       completeDAWU, dawuMisalignedException;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [31:0] cur_addr;
   logic [1:0]  cur_nb;
   logic [1:0]  cnt;
   logic [1:0]  nb_reg;

   // Output vector order:
   // Ld{Addr,Data,NumBytes}, iniCnt, incCnt, initValueCnt[1:0], zero{Addr,Data,NumBytes,Cnt},
   // enableAddr, enableData, checkMisalignedDAWU, writeMem, completeDAWU, dawuMisalignedException
   logic [16:0] outv;
   assign outv = {LdAddr, LdData, LdNumBytes, iniCnt, incCnt, initValueCnt,
                  zeroAddr, zeroData, zeroNumBytes, zeroCnt,
                  enableAddr, enableData, checkMisalignedDAWU, writeMem,
                  completeDAWU, dawuMisalignedException};

   localparam logic [16:0] V_DONE = 17'b0000_0_00_1111_00_0_0_1_0;
   localparam logic [16:0] V_ERR  = 17'b0000_0_00_0000_00_0_0_0_1;

   aftab_dawu_controller dut (
      .clk(clk), .rst(rst), .startDAWU(startDAWU), .memReady(memReady), .coCnt(coCnt),
      .storeMisalignedFlag(storeMisalignedFlag),
      .LdAddr(LdAddr), .LdData(LdData), .LdNumBytes(LdNumBytes), .iniCnt(iniCnt),
      .incCnt(incCnt), .initValueCnt(initValueCnt),
      .zeroAddr(zeroAddr), .zeroData(zeroData), .zeroNumBytes(zeroNumBytes), .zeroCnt(zeroCnt),
      .enableAddr(enableAddr), .enableData(enableData),
      .checkMisalignedDAWU(checkMisalignedDAWU), .writeMem(writeMem),
      .completeDAWU(completeDAWU), .dawuMisalignedException(dawuMisalignedException)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic bit misaligned(input logic [31:0] a, input logic [1:0] nb);
      return (nb == 2'd1 && a[0]) || (nb == 2'd3 && a[1:0] != 2'b00);
   endfunction

   // Datapath model: byte counter, stored size, error detector
   always @(posedge clk) begin
      if (rst) begin
         cnt    <= 2'd0;
         nb_reg <= 2'd0;
      end else begin
         if (iniCnt)            cnt <= initValueCnt;
         else if (zeroCnt)      cnt <= 2'd0;
         else if (incCnt)       cnt <= cnt + 2'd1;
         if (LdNumBytes)        nb_reg <= cur_nb;
         else if (zeroNumBytes) nb_reg <= 2'd0;
      end
   end
   assign coCnt               = (cnt == nb_reg);
   assign storeMisalignedFlag = checkMisalignedDAWU && misaligned(cur_addr, cur_nb);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One store from its start cycle through the DONE/ERROR pulse; returns at the first IDLE cycle.
   task automatic run_store(input logic [31:0] addr, input logic [1:0] nb,
                            input int forced_stalls, input int p_stall, input bit hold);
      bit mis;
      bit rdy;
      int t0, stalls, accepted, guard;
      cur_addr  = addr;
      cur_nb    = nb;
      mis       = MIS_EN && misaligned(addr, nb);
      startDAWU = 1'b1;
      memReady  = 1'($urandom_range(0, 1));
      #1;
      t0 = cyc;
      chk("start", 32'(outv), 32'({{4{~mis}}, 1'b0, 2'b00, 4'b0000, 2'b00, MIS_EN, 1'b0, 1'b0, 1'b0}));
      tick();
      if (mis) begin
         startDAWU = hold;
         memReady  = 1'b1;
         #1;
         chk("misaligned_exc", 32'(outv), 32'(V_ERR));
         chk("misaligned_lat", 32'(cyc - t0), 32'd1);
         tick();
      end else begin
         accepted = 0;
         stalls   = 0;
         guard    = 0;
         while (accepted <= int'(nb) && guard < 40) begin
            if (guard < forced_stalls)           rdy = 1'b0;
            else if (guard >= forced_stalls + 8) rdy = 1'b1;
            else                                 rdy = ($urandom_range(0, 99) >= p_stall);
            memReady  = rdy;
            startDAWU = hold;
            #1;
            chk("write", 32'(outv),
                32'({4'b0000, (rdy && accepted < int'(nb)), 2'b00, 4'b0000, 2'b11, 1'b0, 1'b1, 2'b00}));
            chk("byte_idx", 32'(cnt), 32'(accepted));
            if (rdy) accepted++;
            else     stalls++;
            guard++;
            tick();
         end
         memReady  = 1'($urandom_range(0, 1));
         startDAWU = hold;
         #1;
         chk("done", 32'(outv), 32'(V_DONE));
         chk("latency", 32'(cyc - t0), 32'(int'(nb) + 2 + stalls));
         tick();
      end
   endtask

   task automatic idle_check(input string tag);
      startDAWU = 1'b0;
      memReady  = 1'($urandom_range(0, 1));
      #1;
      chk(tag, 32'(outv), 32'd0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  nbs [3];
      logic [31:0] a;
      nbs[0] = 2'd0; nbs[1] = 2'd1; nbs[2] = 2'd3;
      rst       = 1'b1;
      startDAWU = 1'b0;
      memReady  = 1'b1;
      cur_addr  = 32'h0;
      cur_nb    = 2'd0;
      tick();
      chk("reset_outputs", 32'(outv), 32'd0);
      tick();
      rst = 1'b0;
      idle_check("idle_after_reset");

      // Word store, no stalls: 4 writes, 3 increments, done 5 cycles after start
      run_store(32'h100, 2'd3, 0, 0, 1'b0);
      idle_check("idle_after_word");

      // Byte store with 2 stall cycles: done 4 cycles after start
      run_store(32'h204, 2'd0, 2, 0, 1'b0);
      idle_check("idle_after_byte");

      // Misaligned halfword: exception with the check built in, normal 2-byte store otherwise
      run_store(32'h303, 2'd1, 0, 0, 1'b0);
      idle_check("idle_after_misaligned");

      // Reset in the 2nd WRITE cycle of a word store
      cur_addr  = 32'h400;
      cur_nb    = 2'd3;
      startDAWU = 1'b1;
      memReady  = 1'b1;
      tick();
      startDAWU = 1'b0;
      #1;
      chk("rst_w1_write", 32'(writeMem), 32'd1);
      tick();
      rst = 1'b1;
      #1;
      chk("rst_w2_write", 32'(writeMem), 32'd1);
      tick();
      rst = 1'b0;
      #1;
      chk("rst_midwrite_outputs", 32'(outv), 32'd0);
      tick();
      for (int i = 0; i < 3; i++) idle_check("rst_no_complete");
      run_store(32'h500, 2'd3, 0, 30, 1'b0);
      idle_check("idle_after_rst_recovery");

      // Start held high through a store, next start sampled in the first IDLE cycle
      run_store(32'h600, 2'd3, 0, 0, 1'b1);
      run_store(32'h700, 2'd1, 0, 0, 1'b0);
      idle_check("idle_after_back_to_back");

      // Randomised stores: sizes, alignment, stalls, held start, idle gaps
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         run_store(a, nbs[$urandom_range(0, 2)], 0, $urandom_range(0, 60), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) == 0) idle_check("idle_random");
      end
      idle_check("idle_final");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
